// File: rtl/alu_ctrl_issue.sv
// Execute-stage issue register: decodes ALUOp/funct into the ALU control
// code and registers code + operands toward the ALU, with MUL occupancy,
// stall and flush sequencing.
// Ports: clk_i, rst_i (async, active-low), valid_i/ready_o (ID handshake),
// ALUOp_i, funct_i, data1_i, data2_i, stall_i, flush_i,
// valid_o, ALUCtrl_o, data1_o, data2_o, illegal_o.
module alu_ctrl_issue #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        ALUOp_i,
  input  logic [9:0]        funct_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [3:0]        ALUCtrl_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic              illegal_o
);

  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_MUL = 4'b1000;

  localparam logic [3:0] BUSY_INIT = 4'(MUL_LAT - 1);

  typedef enum logic {
    RUN,
    MUL_BUSY
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [3:0]        code_q, code_d;
  logic [DATA_W-1:0] d1_q, d1_d;
  logic [DATA_W-1:0] d2_q, d2_d;
  logic              ill_q, ill_d;

  logic [3:0] dec_code;
  logic       dec_ill;
  logic       accept;

  always_comb begin
    dec_code = C_AND;
    dec_ill  = 1'b0;
    unique case (ALUOp_i)
      2'b00: dec_code = C_ADD;
      2'b01: dec_code = C_SUB;
      2'b10: begin
        unique case (funct_i)
          10'b0000000_000: dec_code = C_ADD;
          10'b0100000_000: dec_code = C_SUB;
          10'b0000000_111: dec_code = C_AND;
          10'b0000000_110: dec_code = C_OR;
          10'b0000001_000: dec_code = C_MUL;
          default: begin
            dec_code = C_AND;
            dec_ill  = 1'b1;
          end
        endcase
      end
      default: begin
        unique case (funct_i[2:0])
          3'b000: dec_code = C_ADD;
          3'b111: dec_code = C_AND;
          3'b110: dec_code = C_OR;
          default: begin
            dec_code = C_AND;
            dec_ill  = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign ready_o = (state_q == RUN) & ~stall_i & ~flush_i;
  assign accept  = valid_i & ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    code_d  = code_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    ill_d   = ill_q;
    if (flush_i) begin
      state_d = RUN;
      cnt_d   = 4'd0;
      valid_d = 1'b0;
      code_d  = C_ADD;
      d1_d    = '0;
      d2_d    = '0;
      ill_d   = 1'b0;
    end else if (!stall_i) begin
      valid_d = 1'b0;
      code_d  = C_ADD;
      d1_d    = '0;
      d2_d    = '0;
      ill_d   = 1'b0;
      if (accept) begin
        valid_d = 1'b1;
        code_d  = dec_code;
        d1_d    = data1_i;
        d2_d    = data2_i;
        ill_d   = dec_ill;
        if (dec_code == C_MUL && MUL_LAT > 1) begin
          state_d = MUL_BUSY;
          cnt_d   = BUSY_INIT;
        end
      end else if (state_q == MUL_BUSY) begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RUN;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      code_q  <= C_ADD;
      d1_q    <= '0;
      d2_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      ill_q   <= ill_d;
    end
  end

  assign valid_o   = valid_q;
  assign ALUCtrl_o = code_q;
  assign data1_o   = d1_q;
  assign data2_o   = d2_q;
  assign illegal_o = ill_q;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Self-checking bench for alu_ctrl_issue: decode table, directed
// MUL/stall/flush/reset sequences and a randomized run against a model.
module tb_alu_ctrl_issue;

  localparam int DW  = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic          ready;
  logic [1:0]    aluop;
  logic [9:0]    funct;
  logic [DW-1:0] d1, d2;
  logic          stall, flush;
  logic          vo;
  logic [3:0]    code;
  logic [DW-1:0] q1, q2;
  logic          ill;

  int total = 0;
  int bad   = 0;

  alu_ctrl_issue #(.DATA_W(DW), .MUL_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .valid_i(valid), .ready_o(ready),
    .ALUOp_i(aluop), .funct_i(funct),
    .data1_i(d1), .data2_i(d2),
    .stall_i(stall), .flush_i(flush),
    .valid_o(vo), .ALUCtrl_o(code),
    .data1_o(q1), .data2_o(q2),
    .illegal_o(ill)
  );

  always #5 clk = ~clk;

  // reference state: what the ALU should see, plus the first cycle index
  // at which the issuer is free again after a MUL
  logic          m_v;
  logic [3:0]    m_code;
  logic [DW-1:0] m_d1, m_d2;
  logic          m_ill;
  int            cyc = 0;
  int            free_at = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void ref_dec(input logic [1:0] op,
                                  input logic [9:0] f,
                                  output logic [3:0] c,
                                  output logic il);
    il = 1'b0;
    c  = 4'b0000;
    if (op == 2'd0) c = 4'b0010;
    else if (op == 2'd1) c = 4'b0110;
    else if (op == 2'd2) begin
      if (f == 10'b0000000000) c = 4'b0010;
      else if (f == 10'b0100000000) c = 4'b0110;
      else if (f == 10'b0000000111) c = 4'b0000;
      else if (f == 10'b0000000110) c = 4'b0001;
      else if (f == 10'b0000001000) c = 4'b1000;
      else il = 1'b1;
    end else begin
      if (f[2:0] == 3'b000) c = 4'b0010;
      else if (f[2:0] == 3'b111) c = 4'b0000;
      else if (f[2:0] == 3'b110) c = 4'b0001;
      else il = 1'b1;
    end
  endfunction

  task automatic m_bubble();
    m_v = 0; m_code = 4'b0010; m_d1 = '0; m_d2 = '0; m_ill = 0;
  endtask

  task automatic chk_out();
    chk("valid_o", vo, m_v);
    chk("ALUCtrl_o", code, m_code);
    chk("data1_o", q1, m_d1);
    chk("data2_o", q2, m_d2);
    chk("illegal_o", ill, m_ill);
  endtask

  // called just after a falling edge with inputs already driven
  task automatic step();
    logic       er;
    logic [3:0] c;
    logic       il;
    #1;
    er = (cyc >= free_at) && !stall && !flush;
    chk("ready_o", ready, er);
    @(posedge clk);
    if (flush) begin
      m_bubble();
      free_at = cyc + 1;
    end else if (stall) begin
      if (cyc < free_at) free_at++;
    end else if (er && valid) begin
      ref_dec(aluop, funct, c, il);
      m_v = 1; m_code = c; m_d1 = d1; m_d2 = d2; m_ill = il;
      if (c == 4'b1000) free_at = cyc + LAT;
    end else begin
      m_bubble();
    end
    cyc++;
    @(negedge clk);
    chk_out();
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    m_bubble();
    free_at = cyc;
    chk_out();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op,
                       input logic [9:0] f, input logic [DW-1:0] a,
                       input logic [DW-1:0] b);
    valid = v; aluop = op; funct = f; d1 = a; d2 = b;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [9:0] f;
    logic [31:0] a, b;
    logic [3:0] ec;
    logic ei;
  } vec_t;

  vec_t tbl[12];

  localparam logic [9:0] F_MUL = 10'b0000001_000;

  initial begin
    tbl[0]  = '{2'b10, 10'b0100000_000, 9, 4, 4'b0110, 0};
    tbl[1]  = '{2'b10, 10'b0000000_000, 1, 2, 4'b0010, 0};
    tbl[2]  = '{2'b10, 10'b0000000_111, 3, 4, 4'b0000, 0};
    tbl[3]  = '{2'b10, 10'b0000000_110, 5, 6, 4'b0001, 0};
    tbl[4]  = '{2'b10, 10'b0100000_000, 7, 8, 4'b0110, 0};
    tbl[5]  = '{2'b00, 10'b1111111_111, 11, 12, 4'b0010, 0};
    tbl[6]  = '{2'b01, 10'b0000001_000, 13, 14, 4'b0110, 0};
    tbl[7]  = '{2'b10, 10'b0000000_001, 15, 16, 4'b0000, 1};
    tbl[8]  = '{2'b11, 10'b0000000_000, 17, 18, 4'b0010, 0};
    tbl[9]  = '{2'b11, 10'b0100000_111, 19, 20, 4'b0000, 0};
    tbl[10] = '{2'b11, 10'b1010101_110, 21, 22, 4'b0001, 0};
    tbl[11] = '{2'b11, 10'b0000000_010, 23, 24, 4'b0000, 1};

    rst_n = 0; stall = 0; flush = 0;
    drive(0, 0, 0, 0, 0);
    m_bubble();
    @(negedge clk);
    chk_out();
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      drive(1, tbl[i].op, tbl[i].f, tbl[i].a, tbl[i].b);
      step();
      chk("tbl_code", code, tbl[i].ec);
      chk("tbl_ill", ill, tbl[i].ei);
      chk("tbl_d1", q1, tbl[i].a);
      chk("tbl_v", vo, 1);
    end

    drive(1, 2'b10, F_MUL, 7, 6);
    step();
    chk("mul_code", code, 4'b1000);
    drive(1, 2'b00, 0, 1, 2);
    step();
    chk("mul_bub1", vo, 0);
    step();
    chk("mul_bub2", vo, 0);
    step();
    chk("after_mul", {vo, code}, {1'b1, 4'b0010});

    drive(1, 2'b00, 0, 5, 3);
    step();
    stall = 1;
    drive(1, 2'b01, 0, 8, 8);
    step();
    step();
    chk("stall_hold", {vo, code, q1, q2}, {1'b1, 4'b0010, 32'd5, 32'd3});
    stall = 0;
    step();
    chk("stall_rel", {vo, code, q1}, {1'b1, 4'b0110, 32'd8});

    drive(1, 2'b10, F_MUL, 2, 3);
    step();
    flush = 1; stall = 1;
    step();
    chk("flush", {vo, code}, {1'b0, 4'b0010});
    flush = 0;
    step();
    stall = 0;
    #1 chk("flush_rdy", ready, 1);
    drive(1, 2'b10, F_MUL, 4, 4);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    do_reset();
    chk("rst_mid", {vo, code}, {1'b0, 4'b0010});
    drive(1, 2'b00, 0, 9, 9);
    step();

    for (int n = 0; n < 400; n++) begin
      logic [2:0] pick;
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 4) == 0);
      valid = ($urandom_range(0, 9) < 7);
      aluop = 2'($urandom);
      pick  = 3'($urandom);
      case (pick)
        0: funct = F_MUL;
        1: funct = 10'b0100000_000;
        2: funct = 10'b0000000_111;
        3: funct = 10'b0000000_110;
        4: funct = 10'b0000000_000;
        default: funct = 10'($urandom);
      endcase
      d1 = $urandom;
      d2 = $urandom;
      step();
      if (n == 200) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
